// File: rtl/store_buffer_bridge_if.sv
// ---------------------------------------------------------------------------
// store_buffer_bridge_if
//
// Purpose: handshaked, variable-latency data-memory bus between the store
// buffer bridge (master) and the memory system (slave).
//
// Signals:
//   MemReq   master->slave  request valid, held until the MemAck cycle
//   MemWe    master->slave  1 = write, 0 = read (valid while MemReq=1)
//   MemAdr   master->slave  word-aligned byte address
//   MemWData master->slave  write data
//   MemAck   slave->master  request accepted/completed this cycle
//   MemRData slave->master  read data, valid in the MemAck cycle of a read
// ---------------------------------------------------------------------------
interface store_buffer_bridge_if;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAdr;
   logic [31:0] MemWData;
   logic        MemAck;
   logic [31:0] MemRData;

   modport master (
      output MemReq,
      output MemWe,
      output MemAdr,
      output MemWData,
      input  MemAck,
      input  MemRData
   );

   modport slave (
      input  MemReq,
      input  MemWe,
      input  MemAdr,
      input  MemWData,
      output MemAck,
      output MemRData
   );
endinterface

// File: rtl/store_buffer_bridge.sv
// ---------------------------------------------------------------------------
// store_buffer_bridge
//
// Purpose: connects a single-cycle core's data port to a handshaked memory
// bus. Stores are posted into a DEPTH-entry FIFO and drained in order in the
// background; loads go to the bus and stall the core until data returns.
//
// Optional feature macro: SB_FWD_EN
//   defined   : loads compare against every buffered store (head included);
//               a hit returns the youngest matching data combinationally with
//               no stall; load misses take priority over the drain.
//   undefined : no address compare; a load waits until the buffer is fully
//               drained and the FSM is idle, then issues a bus read.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      synchronous, active-low
//   MemWrite   core store request
//   MemRead    core load request
//   DataAdr    core byte address ([1:0] ignored)
//   WriteData  core store data
//   ReadData   load data to core
//   Stall      core must hold PC and data-port inputs while 1
//   bus        memory bus, master side (see store_buffer_bridge_if)
// ---------------------------------------------------------------------------
module store_buffer_bridge #(
   parameter int DEPTH = 4,
   parameter int AW    = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 MemWrite,
   input  logic                 MemRead,
   input  logic [31:0]          DataAdr,
   input  logic [31:0]          WriteData,
   output logic [31:0]          ReadData,
   output logic                 Stall,
   store_buffer_bridge_if.master bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [AW-1:0]   fifo_adr_q [DEPTH];
   logic [31:0]     fifo_dat_q [DEPTH];

   logic [AW-1:0]   word_adr;
   logic            full;
   logic            push;
   logic            pop;
   logic            fwd_hit;
   logic [31:0]     fwd_data;
   logic            load_miss;
   logic            unused_adr_bits;

   assign word_adr        = DataAdr[AW+1:2];
   assign unused_adr_bits = ^DataAdr[1:0];

   assign full = (count_q == CW'(DEPTH));
   // A simultaneous load wins; the store half of an illegal load+store is dropped.
   assign push = MemWrite && !MemRead && !full;
   assign pop  = (state_q == WR) && bus.MemAck;

`ifdef SB_FWD_EN
   logic [DEPTH-1:0] entry_match;
   logic [PW-1:0]    scan_idx;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
         logic [PW-1:0] age;
         // Entry is live when its distance from head is below count.
         assign age             = PW'(gi) - head_q;
         assign entry_match[gi] = (CW'(age) < count_q) && (fifo_adr_q[gi] == word_adr);
      end
   endgenerate

   // Scan oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      scan_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head_q + PW'(k);
         if (entry_match[scan_idx]) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_dat_q[scan_idx];
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   assign load_miss = MemRead && !fwd_hit;

   // Next-state and bus register logic.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
`ifdef SB_FWD_EN
            if (load_miss) begin
               state_d = RD;
               req_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = word_adr;
            end else if (count_q != '0) begin
               state_d = WR;
               req_d   = 1'b1;
               we_d    = 1'b1;
               adr_d   = fifo_adr_q[head_q];
               wdata_d = fifo_dat_q[head_q];
            end
`else
            // Full drain before any read keeps loads ordered after stores.
            if (count_q != '0) begin
               state_d = WR;
               req_d   = 1'b1;
               we_d    = 1'b1;
               adr_d   = fifo_adr_q[head_q];
               wdata_d = fifo_dat_q[head_q];
            end else if (MemRead) begin
               state_d = RD;
               req_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = word_adr;
            end
`endif
         end
         WR: begin
            if (bus.MemAck) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         RD: begin
            if (bus.MemAck) begin
               state_d = RDONE;
               req_d   = 1'b0;
               rdata_d = bus.MemRData;
            end
         end
         RDONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         req_q   <= req_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Entry storage needs no reset: liveness comes from head/count.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         fifo_adr_q[tail_q] <= word_adr;
         fifo_dat_q[tail_q] <= WriteData;
      end
   end

   // In RDONE the captured bus data is returned regardless of the compare.
   assign ReadData = (fwd_hit && (state_q != RDONE)) ? fwd_data : rdata_q;
   assign Stall    = (load_miss && (state_q != RDONE)) || (MemWrite && !MemRead && full);

   assign bus.MemReq   = req_q;
   assign bus.MemWe    = we_q;
   assign bus.MemAdr   = 32'({adr_q, 2'b00});
   assign bus.MemWData = wdata_q;

endmodule

// File: tb/tb_store_buffer_bridge.sv
module tb_store_buffer_bridge;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        Stall;

   store_buffer_bridge_if bus_if ();

   store_buffer_bridge #(.DEPTH(DEPTH), .AW(30)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        wr;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        ack;
      logic        e_stall;
      logic        e_req;
      logic [31:0] e_adr;
      logic [31:0] e_wd;
   } vec_t;

   vec_t vt [17];

   // ---------------- reference model state ----------------
   logic [29:0] sq_adr [$];
   logic [31:0] sq_dat [$];
   logic [31:0] mem_m [logic [29:0]];

   function automatic logic [31:0] mem_rd(input logic [29:0] w);
      if (mem_m.exists(w)) return mem_m[w];
      return {w, 2'b11} ^ 32'hA5C3_0F96;
   endfunction

   function automatic bit sq_find(input logic [29:0] w, output logic [31:0] d);
      bit found = 1'b0;
      d = '0;
      for (int i = 0; i < sq_adr.size(); i++) begin
         if (sq_adr[i] == w) begin
            found = 1'b1;
            d     = sq_dat[i];
         end
      end
      return found;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; bus_if.MemAck = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic load_miss(input logic [31:0] adr, input int ack_cycle,
                            input logic [31:0] dat, input int exp_stalls);
      int  stalls = 0;
      int  reqc   = 0;
      bit  done   = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(posedge clk); #1;
         MemRead = 1'b1; DataAdr = adr;
         if (bus_if.MemReq) reqc++;
         bus_if.MemAck   = bus_if.MemReq && (reqc == ack_cycle);
         bus_if.MemRData = bus_if.MemAck ? dat : 32'h0;
         @(negedge clk);
         if (bus_if.MemAck) chk("ld_miss_adr", 128'(bus_if.MemAdr), 128'({adr[31:2], 2'b00}));
         if (Stall) stalls++;
         else begin
            chk("ld_miss_data", 128'(ReadData), 128'(dat));
            done = 1'b1;
         end
      end
      chk("ld_miss_done", 128'(done), 128'(1));
      chk("ld_miss_stalls", 128'(stalls), 128'(exp_stalls));
      $display("load miss adr=%h ack_cycle=%0d stalls=%0d data=%h", adr, ack_cycle, stalls, ReadData);
      @(posedge clk); #1;
      MemRead = 1'b0; bus_if.MemAck = 1'b0;
   endtask

   // random-phase bookkeeping
   bit          op_active, op_load, op_hit, ev_push, ev_pop, abort;
   logic [31:0] op_adr, op_dat, op_exp;
   logic [29:0] push_adr;
   logic [31:0] push_dat;
   int          op_cyc, ops_done, req_age, lat;
   logic        prev_req, prev_we, prev_ack;
   logic [31:0] prev_adr, prev_wd;
   int          wr_seen, rd_seen;

   initial begin
      bus_if.MemAck   = 1'b0;
      bus_if.MemRData = '0;

      // ---- reset then idle ----
      do_reset();
      @(negedge clk);
      chk("rst_out", 128'({ReadData, Stall, bus_if.MemReq, bus_if.MemWe, bus_if.MemAdr, bus_if.MemWData}), 128'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_idle_req", 128'(bus_if.MemReq), 128'(0));
      end
      $display("reset check done");

      // ---- full buffer / ordered drain table ----
      vt[0]  = '{1'b1, 32'h60, 32'd1, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0};
      vt[1]  = '{1'b1, 32'h64, 32'd2, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0};
      vt[2]  = '{1'b1, 32'h68, 32'd3, 1'b0, 1'b0, 1'b1, 32'h60, 32'd1};
      vt[3]  = '{1'b1, 32'h6C, 32'd4, 1'b0, 1'b0, 1'b1, 32'h60, 32'd1};
      vt[4]  = '{1'b1, 32'h70, 32'd5, 1'b0, 1'b1, 1'b1, 32'h60, 32'd1};
      vt[5]  = '{1'b1, 32'h70, 32'd5, 1'b1, 1'b1, 1'b1, 32'h60, 32'd1};
      vt[6]  = '{1'b1, 32'h70, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0};
      vt[7]  = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 1'b1, 32'h64, 32'd2};
      vt[8]  = '{1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b1, 32'h64, 32'd2};
      vt[9]  = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0};
      vt[10] = '{1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b1, 32'h68, 32'd3};
      vt[11] = '{1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 32'h0,  32'd0};
      vt[12] = '{1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b1, 32'h6C, 32'd4};
      vt[13] = '{1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b0, 32'h0,  32'd0};
      vt[14] = '{1'b0, 32'h0,  32'd0, 1'b1, 1'b0, 1'b1, 32'h70, 32'd5};
      vt[15] = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0};
      vt[16] = '{1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0};
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         MemWrite = vt[i].wr; MemRead = 1'b0;
         DataAdr = vt[i].adr; WriteData = vt[i].dat;
         bus_if.MemAck = vt[i].ack;
         @(negedge clk);
         chk("vec_stall", 128'(Stall), 128'(vt[i].e_stall));
         chk("vec_req", 128'(bus_if.MemReq), 128'(vt[i].e_req));
         if (vt[i].e_req)
            chk("vec_bus", 128'({bus_if.MemWe, bus_if.MemAdr, bus_if.MemWData}),
                128'({1'b1, vt[i].e_adr, vt[i].e_wd}));
         $display("vec %0d wr=%0d adr=%h ack=%0d stall=%0d req=%0d madr=%h", i, vt[i].wr,
                  vt[i].adr, vt[i].ack, Stall, bus_if.MemReq, bus_if.MemAdr);
      end
      @(posedge clk); #1;
      MemWrite = 1'b0; bus_if.MemAck = 1'b0;

      // ---- load miss latency ----
      load_miss(32'h20, 1, 32'h1234_5678, 2);
      load_miss(32'h20, 3, 32'hDEAD_BEEF, 4);

`ifdef SB_FWD_EN
      // ---- forwarding, youngest wins ----
      @(posedge clk); #1;
      MemWrite = 1'b1; DataAdr = 32'h64; WriteData = 32'd7;
      @(negedge clk); chk("fw_st1_stall", 128'(Stall), 128'(0));
      @(posedge clk); #1;
      MemWrite = 1'b0; MemRead = 1'b1;
      @(negedge clk);
      chk("fw_ld1_stall", 128'(Stall), 128'(0));
      chk("fw_ld1_data", 128'(ReadData), 128'(7));
      chk("fw_ld1_noreq", 128'(bus_if.MemReq), 128'(0));
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b1; WriteData = 32'd9;
      @(negedge clk); chk("fw_st2_stall", 128'(Stall), 128'(0));
      @(posedge clk); #1;
      MemWrite = 1'b0; MemRead = 1'b1;
      @(negedge clk);
      chk("fw_ld2_stall", 128'(Stall), 128'(0));
      chk("fw_ld2_data", 128'(ReadData), 128'(9));
      @(posedge clk); #1;
      MemRead = 1'b0; bus_if.MemAck = 1'b1;
      wr_seen = 0; rd_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_if.MemReq && !bus_if.MemWe) rd_seen++;
         if (bus_if.MemReq && bus_if.MemWe && bus_if.MemAck) wr_seen++;
         @(posedge clk); #1;
      end
      bus_if.MemAck = 1'b0;
      chk("fw_no_bus_read", 128'(rd_seen), 128'(0));
      chk("fw_drain_writes", 128'(wr_seen), 128'(2));
      $display("forwarding sequence done writes=%0d reads=%0d", wr_seen, rd_seen);
`endif

      // ---- reset mid-drain ----
      bus_if.MemAck = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         MemWrite = 1'b1; DataAdr = 32'h80 + 32'(4 * i); WriteData = 32'(10 + i);
      end
      @(posedge clk); #1;
      MemWrite = 1'b0;
      @(negedge clk); chk("rst_pre_req", 128'(bus_if.MemReq), 128'(1));
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_bus", 128'({bus_if.MemReq, bus_if.MemWe, bus_if.MemAdr, bus_if.MemWData}), 128'(0));
      chk("rst_mid_stall", 128'(Stall), 128'(0));
      bus_if.MemAck = 1'b1;
      wr_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_if.MemReq) wr_seen++;
      end
      bus_if.MemAck = 1'b0;
      chk("rst_no_writes", 128'(wr_seen), 128'(0));
      $display("reset mid-drain done requests after reset=%0d", wr_seen);

      // ---- randomized run against the reference model ----
      do_reset();
      op_active = 1'b0; ev_push = 1'b0; ev_pop = 1'b0; abort = 1'b0;
      ops_done = 0; req_age = 0; lat = 0;
      prev_req = 1'b0; prev_we = 1'b0; prev_ack = 1'b0; prev_adr = '0; prev_wd = '0;
      for (int cyc = 0; cyc < 8000 && ops_done < 400 && !abort; cyc++) begin
         @(posedge clk); #1;
         if (ev_pop && sq_adr.size() > 0) begin
            mem_m[sq_adr[0]] = sq_dat[0];
            void'(sq_adr.pop_front());
            void'(sq_dat.pop_front());
         end
         if (ev_push) begin
            sq_adr.push_back(push_adr);
            sq_dat.push_back(push_dat);
         end
         ev_push = 1'b0; ev_pop = 1'b0;
         if (!op_active) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 8) begin
               op_active = 1'b1;
               op_load   = (r >= 4);
               op_adr    = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
               op_dat    = $urandom;
               op_cyc    = 0;
            end
         end
         MemWrite  = op_active && !op_load;
         MemRead   = op_active && op_load;
         DataAdr   = op_adr;
         WriteData = op_dat;
         if (bus_if.MemReq) begin
            if (prev_req && !prev_ack) req_age++;
            else begin
               req_age = 0;
               lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            end
            bus_if.MemAck = (req_age >= lat);
         end else begin
            bus_if.MemAck = 1'b0;
         end
         bus_if.MemRData = (bus_if.MemReq && !bus_if.MemWe) ? mem_rd(bus_if.MemAdr[31:2]) : $urandom;

         @(negedge clk);
         // bus protocol and store order
         if (prev_req && !prev_ack)
            chk("bus_hold", 128'({bus_if.MemReq, bus_if.MemWe, bus_if.MemAdr, bus_if.MemWData}),
                128'({1'b1, prev_we, prev_adr, prev_wd}));
         if (prev_req && prev_ack)
            chk("req_gap", 128'(bus_if.MemReq), 128'(0));
         if (bus_if.MemReq && bus_if.MemAck && bus_if.MemWe) begin
            if (sq_adr.size() == 0) chk("wr_unexpected", 128'(1), 128'(0));
            else begin
               chk("wr_order", 128'({bus_if.MemAdr, bus_if.MemWData}), 128'({sq_adr[0], 2'b00, sq_dat[0]}));
               ev_pop = 1'b1;
            end
         end
         if (bus_if.MemReq && bus_if.MemAck && !bus_if.MemWe) begin
            if (!(op_active && op_load)) chk("rd_unexpected", 128'(1), 128'(0));
            else begin
               chk("rd_adr", 128'(bus_if.MemAdr), 128'({op_adr[31:2], 2'b00}));
`ifdef SB_FWD_EN
               chk("rd_on_hit", 128'(op_hit), 128'(0));
`else
               chk("rd_drained", 128'(sq_adr.size()), 128'(0));
`endif
            end
         end
         // core-side transaction
         if (op_active) begin
            op_cyc++;
            if (!op_load) begin
               chk("st_stall", 128'(Stall), 128'(sq_adr.size() == DEPTH));
               if (sq_adr.size() < DEPTH) begin
                  ev_push   = 1'b1;
                  push_adr  = op_adr[31:2];
                  push_dat  = op_dat;
                  op_active = 1'b0;
                  ops_done++;
                  $display("op %0d store adr=%h data=%h cycles=%0d", ops_done, op_adr, op_dat, op_cyc);
               end
            end else begin
               if (op_cyc == 1) begin
                  op_hit = sq_find(op_adr[31:2], op_exp);
                  if (!op_hit) op_exp = mem_rd(op_adr[31:2]);
`ifdef SB_FWD_EN
                  chk("ld_first_stall", 128'(Stall), 128'(!op_hit));
`else
                  chk("ld_first_stall", 128'(Stall), 128'(1));
`endif
               end
               if (!Stall) begin
                  chk("ld_data", 128'(ReadData), 128'(op_exp));
                  op_active = 1'b0;
                  ops_done++;
                  $display("op %0d load  adr=%h data=%h cycles=%0d", ops_done, op_adr, ReadData, op_cyc);
               end
            end
            if (op_active && op_cyc > 200) begin
               chk("op_timeout", 128'(1), 128'(0));
               abort = 1'b1;
            end
         end
         prev_req = bus_if.MemReq;
         prev_we  = bus_if.MemWe;
         prev_adr = bus_if.MemAdr;
         prev_wd  = bus_if.MemWData;
         prev_ack = bus_if.MemAck;
      end
      chk("rand_ops_done", 128'(ops_done), 128'(400));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
